// File: rtl/ula_pkg.sv
// ula_pkg: select codes and state encoding shared by ula_seq and the ALU control decoder.
package ula_pkg;

    localparam logic [3:0] ULA_ADD  = 4'b0001;
    localparam logic [3:0] ULA_SUB  = 4'b0010;
    localparam logic [3:0] ULA_SLL  = 4'b0011;
    localparam logic [3:0] ULA_SLT  = 4'b0100;
    localparam logic [3:0] ULA_SLTU = 4'b0101;
    localparam logic [3:0] ULA_SRL  = 4'b0110;
    localparam logic [3:0] ULA_SRA  = 4'b0111;
    localparam logic [3:0] ULA_XOR  = 4'b1000;
    localparam logic [3:0] ULA_OR   = 4'b1001;
    localparam logic [3:0] ULA_AND  = 4'b1010;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } ula_state_e;

    function automatic logic is_shift(input logic [3:0] sel);
        return (sel == ULA_SLL) || (sel == ULA_SRL) || (sel == ULA_SRA);
    endfunction

endpackage

// File: rtl/ula_if.sv
// ula_if: request/result bundle between the issuing stage (master) and ula_seq (slave).
interface ula_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [3:0]      select;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;
    logic            zero;

    modport master (output start, select, a, b, input busy, done, result, zero);
    modport slave  (input start, select, a, b, output busy, done, result, zero);
endinterface

// File: rtl/ula_shifter.sv
// ula_shifter: one-bit shift step by default; full barrel shift when ULA_BARREL_SHIFT_EN is defined.
module ula_shifter
    import ula_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [3:0]              op,
    input  logic [XLEN-1:0]         src,
`ifdef ULA_BARREL_SHIFT_EN
    input  logic [$clog2(XLEN)-1:0] shamt,
`endif
    output logic [XLEN-1:0]         res
);

`ifdef ULA_BARREL_SHIFT_EN
    always_comb begin
        res = src;
        case (op)
            ULA_SLL: res = src << shamt;
            ULA_SRL: res = src >> shamt;
            ULA_SRA: res = $signed(src) >>> shamt;
            default: res = src;
        endcase
    end
`else
    always_comb begin
        res = src;
        case (op)
            ULA_SLL: res = {src[XLEN-2:0], 1'b0};
            ULA_SRL: res = {1'b0, src[XLEN-1:1]};
            ULA_SRA: res = {src[XLEN-1], src[XLEN-1:1]};
            default: res = src;
        endcase
    end
`endif

endmodule

// File: rtl/ula_seq.sv
// ula_seq: sequential ALU, one op per start, registered result with one-cycle done pulse.
// Define ULA_BARREL_SHIFT_EN for single-cycle shifts (no SHIFT state, busy tied low).
module ula_seq
    import ula_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input logic  clk,
    input logic  rst_n,
    ula_if.slave bus
);

    logic [XLEN-1:0] alu_res;
    logic [XLEN-1:0] shift_res;
    logic [XLEN-1:0] result_q, result_d;
    logic            zero_q, zero_d;
    logic            done_q, done_d;
    logic [SHW-1:0]  shamt;

    assign shamt = bus.b[SHW-1:0];

`ifdef ULA_BARREL_SHIFT_EN
    ula_shifter #(.XLEN(XLEN)) u_shifter (
        .op    (bus.select),
        .src   (bus.a),
        .shamt (shamt),
        .res   (shift_res)
    );
`else
    ula_state_e      state_q, state_d;
    logic [3:0]      op_q, op_d;
    logic [XLEN-1:0] acc_q, acc_d;
    logic [SHW-1:0]  cnt_q, cnt_d;

    ula_shifter #(.XLEN(XLEN)) u_shifter (
        .op  (op_q),
        .src (acc_q),
        .res (shift_res)
    );
`endif

    // Single-cycle result; in the iterative build a shift only lands here with shamt 0.
    always_comb begin
        alu_res = '0;
        case (bus.select)
            ULA_ADD:  alu_res = bus.a + bus.b;
            ULA_SUB:  alu_res = bus.a - bus.b;
            ULA_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
            ULA_SLTU: alu_res = {{(XLEN-1){1'b0}}, (bus.a < bus.b)};
            ULA_XOR:  alu_res = bus.a ^ bus.b;
            ULA_OR:   alu_res = bus.a | bus.b;
            ULA_AND:  alu_res = bus.a & bus.b;
`ifdef ULA_BARREL_SHIFT_EN
            ULA_SLL, ULA_SRL, ULA_SRA: alu_res = shift_res;
`else
            ULA_SLL, ULA_SRL, ULA_SRA: alu_res = bus.a;
`endif
            default:  alu_res = '0;
        endcase
    end

    always_comb begin
        result_d = result_q;
        zero_d   = zero_q;
        done_d   = 1'b0;
`ifdef ULA_BARREL_SHIFT_EN
        if (bus.start) begin
            result_d = alu_res;
            zero_d   = (alu_res == '0);
            done_d   = 1'b1;
        end
`else
        state_d = state_q;
        op_d    = op_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    if (is_shift(bus.select) && (shamt != '0)) begin
                        op_d    = bus.select;
                        acc_d   = bus.a;
                        cnt_d   = shamt;
                        state_d = ST_SHIFT;
                    end else begin
                        result_d = alu_res;
                        zero_d   = (alu_res == '0);
                        done_d   = 1'b1;
                    end
                end
            end
            ST_SHIFT: begin
                acc_d = shift_res;
                cnt_d = cnt_q - SHW'(1);
                if (cnt_q == SHW'(1)) begin
                    result_d = shift_res;
                    zero_d   = (shift_res == '0);
                    done_d   = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q <= '0;
            zero_q   <= 1'b1;
            done_q   <= 1'b0;
`ifndef ULA_BARREL_SHIFT_EN
            state_q  <= ST_IDLE;
            op_q     <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
`endif
        end else begin
            result_q <= result_d;
            zero_q   <= zero_d;
            done_q   <= done_d;
`ifndef ULA_BARREL_SHIFT_EN
            state_q  <= state_d;
            op_q     <= op_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
`endif
        end
    end

    assign bus.result = result_q;
    assign bus.zero   = zero_q;
    assign bus.done   = done_q;
`ifdef ULA_BARREL_SHIFT_EN
    assign bus.busy   = 1'b0;
`else
    assign bus.busy   = (state_q == ST_SHIFT);
`endif

endmodule

// File: tb/tb_ula_seq.sv
// tb_ula_seq: directed literal checks plus randomized traffic checked every cycle
// against a latency/result model of the ALU; follows ULA_BARREL_SHIFT_EN like the RTL.
module tb_ula_seq;

`ifdef ULA_BARREL_SHIFT_EN
    localparam bit BARREL = 1'b1;
`else
    localparam bit BARREL = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   test_count = 0;
    int   fail_count = 0;
    bit   chk_en = 1'b0;

    ula_if #(.XLEN(32)) bus ();

    ula_seq #(.XLEN(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference rules: plain arithmetic on the operation codes
    function automatic logic [31:0] ref_op(input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b);
        logic [4:0] sh;
        sh = b[4:0];
        case (sel)
            4'h1: ref_op = a + b;
            4'h2: ref_op = a - b;
            4'h3: ref_op = a << sh;
            4'h4: ref_op = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'h5: ref_op = (a < b) ? 32'd1 : 32'd0;
            4'h6: ref_op = a >> sh;
            4'h7: ref_op = $signed(a) >>> sh;
            4'h8: ref_op = a ^ b;
            4'h9: ref_op = a | b;
            4'hA: ref_op = a & b;
            default: ref_op = 32'd0;
        endcase
    endfunction

    function automatic int ref_lat(input logic [3:0] sel, input logic [31:0] b);
        if (BARREL) return 1;
        if ((sel == 4'h3 || sel == 4'h6 || sel == 4'h7) && b[4:0] != 5'd0) return int'(b[4:0]) + 1;
        return 1;
    endfunction

    int          m_rem;
    logic [31:0] m_pending;
    logic [31:0] m_result;
    logic        m_done;
    logic        m_zero;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_rem     <= 0;
            m_pending <= 32'd0;
            m_result  <= 32'd0;
            m_done    <= 1'b0;
            m_zero    <= 1'b1;
        end else begin
            m_done <= 1'b0;
            if (m_rem > 0) begin
                m_rem <= m_rem - 1;
                if (m_rem == 1) begin
                    m_done   <= 1'b1;
                    m_result <= m_pending;
                    m_zero   <= (m_pending == 32'd0);
                end
            end else if (bus.start) begin
                if (ref_lat(bus.select, bus.b) == 1) begin
                    m_done   <= 1'b1;
                    m_result <= ref_op(bus.select, bus.a, bus.b);
                    m_zero   <= (ref_op(bus.select, bus.a, bus.b) == 32'd0);
                end else begin
                    m_rem     <= ref_lat(bus.select, bus.b) - 1;
                    m_pending <= ref_op(bus.select, bus.a, bus.b);
                end
            end
        end
    end

    task automatic cmpVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        test_count++;
        if (act !== exp) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%h expected 0x%h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            cmpVal("cyc_busy",   {31'd0, bus.busy}, {31'd0, (m_rem != 0)});
            cmpVal("cyc_done",   {31'd0, bus.done}, {31'd0, m_done});
            cmpVal("cyc_result", bus.result, m_result);
            cmpVal("cyc_zero",   {31'd0, bus.zero}, {31'd0, m_zero});
        end
    end

    // Called at a falling edge; start is sampled on the following rising edge
    task automatic applyStimulus(input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b);
        bus.start  = 1'b1;
        bus.select = sel;
        bus.a      = a;
        bus.b      = b;
        @(negedge clk);
        bus.start  = 1'b0;
        bus.select = 4'($urandom_range(0, 15));
        bus.a      = $urandom;
        bus.b      = $urandom;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] exp_res, input logic exp_zero,
                               input int exp_lat, input int exp_busy, input int lat, input int busy_cycles);
        cmpVal({name, "_result"},  bus.result, exp_res);
        cmpVal({name, "_zero"},    {31'd0, bus.zero}, {31'd0, exp_zero});
        cmpVal({name, "_latency"}, lat, exp_lat);
        cmpVal({name, "_busy"},    busy_cycles, exp_busy);
    endtask

    task automatic runOp(input string name, input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_res, input logic exp_zero, input int exp_lat, input int exp_busy);
        int lat;
        int bc;
        applyStimulus(sel, a, b);
        lat = 1;
        bc  = 0;
        while (!bus.done && lat < 100) begin
            if (bus.busy) bc++;
            @(negedge clk);
            lat++;
        end
        checkOutput(name, exp_res, exp_zero, exp_lat, exp_busy, lat, bc);
    endtask

    task automatic checkReset(input string name);
        cmpVal({name, "_busy"},   {31'd0, bus.busy}, 32'd0);
        cmpVal({name, "_done"},   {31'd0, bus.done}, 32'd0);
        cmpVal({name, "_result"}, bus.result, 32'd0);
        cmpVal({name, "_zero"},   {31'd0, bus.zero}, 32'd1);
    endtask

    initial begin
        int dones;
        bus.start  = 1'b0;
        bus.select = 4'h0;
        bus.a      = 32'd0;
        bus.b      = 32'd0;
        #1 rst_n = 1'b0;
        chk_en = 1'b1;
        repeat (2) @(negedge clk);
        checkReset("reset");
        #2 rst_n = 1'b1;
        @(negedge clk);

        runOp("add_ovf",  4'h1, 32'h7FFFFFFF, 32'h1, 32'h80000000, 1'b0, 1, 0);
        runOp("sub_neg",  4'h2, 32'd5, 32'd7, 32'hFFFFFFFE, 1'b0, 1, 0);
        runOp("slt",      4'h4, 32'hFFFFFFFF, 32'h1, 32'h1, 1'b0, 1, 0);
        runOp("sltu",     4'h5, 32'hFFFFFFFF, 32'h1, 32'h0, 1'b1, 1, 0);
        runOp("xor_same", 4'h8, 32'h1234, 32'h1234, 32'h0, 1'b1, 1, 0);
        runOp("sra4",     4'h7, 32'h80000000, 32'h24, 32'hF8000000, 1'b0, BARREL ? 1 : 5, BARREL ? 0 : 4);
        runOp("srl4",     4'h6, 32'h80000000, 32'h24, 32'h08000000, 1'b0, BARREL ? 1 : 5, BARREL ? 0 : 4);
        runOp("sll0",     4'h3, 32'hA5, 32'h0, 32'hA5, 1'b0, 1, 0);
        runOp("sll31",    4'h3, 32'h1, 32'd31, 32'h80000000, 1'b0, BARREL ? 1 : 32, BARREL ? 0 : 31);
        runOp("b2b_add",  4'h1, 32'd2, 32'd3, 32'd5, 1'b0, 1, 0);
        runOp("and_mask", 4'hA, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 1'b0, 1, 0);
        runOp("or_bits",  4'h9, 32'h00000F00, 32'h000000F0, 32'h00000FF0, 1'b0, 1, 0);
        runOp("undef_f",  4'hF, 32'h1234, 32'h5678, 32'h0, 1'b1, 1, 0);
        runOp("add_nz",   4'h1, 32'd9, 32'd1, 32'd10, 1'b0, 1, 0);
        runOp("undef_0",  4'h0, 32'h1, 32'h1, 32'h0, 1'b1, 1, 0);

        // Start held high throughout an 8-bit shift; only the done-cycle start would be legal
        applyStimulus(4'h6, 32'hFFFF0000, 32'd8);
        dones = bus.done ? 1 : 0;
        for (int i = 0; i < 8; i++) begin
            bus.start  = 1'b1;
            bus.select = 4'h1;
            bus.a      = $urandom;
            bus.b      = $urandom;
            @(negedge clk);
            if (bus.done) dones++;
        end
        bus.start = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (bus.done) dones++;
        end
        cmpVal("start_while_busy_dones", dones, BARREL ? 32'd9 : 32'd1);

        runOp("pre_reset", 4'h1, 32'd40, 32'd2, 32'd42, 1'b0, 1, 0);
        applyStimulus(4'h3, 32'h1, 32'd20);
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        @(negedge clk);
        checkReset("midshift_reset");
        #2 rst_n = 1'b1;
        dones = 0;
        repeat (25) begin
            @(negedge clk);
            if (bus.done) dones++;
        end
        cmpVal("no_done_after_reset", dones, 32'd0);

        for (int i = 0; i < 3000; i++) begin
            bus.start  = ($urandom_range(0, 2) != 0);
            bus.select = 4'($urandom_range(0, 15));
            bus.a      = $urandom;
            bus.b      = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 7)) : $urandom;
            if ($urandom_range(0, 7) == 0) bus.b = bus.a;
            if (i == 1500) begin
                #2 rst_n = 1'b0;
                @(negedge clk);
                #2 rst_n = 1'b1;
            end
            @(negedge clk);
        end
        bus.start = 1'b0;
        repeat (40) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
        $finish;
    end

endmodule
